// File: rtl/y_adder_pkg.sv
// Shared constants for the y_adder ripple-carry adder: default width and legal width range.
package y_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;
   localparam int unsigned WIDTH_MIN     = 1;
   localparam int unsigned WIDTH_MAX     = 64;

endpackage : y_adder_pkg

// File: rtl/y_full_adder.sv
// One-bit full adder cell used as a link in the y_adder ripple chain.
module y_full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic z,
   output logic cout
);

   assign z    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : y_full_adder

// File: rtl/y_adder.sv
// Registered WIDTH-bit ripple-carry adder with one-cycle latency.
// Optional signed-overflow output ovf is built only when Y_ADDER_OVF_EN is defined.
module y_adder
   import y_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   output logic [WIDTH-1:0] z,
   output logic             cout,
   output logic             out_valid
`ifdef Y_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("y_adder: WIDTH %0d outside legal range", WIDTH);
   end

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum;

   assign carry[0] = cin;

   // Ripple chain: carry[i] feeds bit i, carry[WIDTH] is the final carry-out.
   for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_fa
      y_full_adder u_fa (
         .a    (a[gi]),
         .b    (b[gi]),
         .cin  (carry[gi]),
         .z    (sum[gi]),
         .cout (carry[gi+1])
      );
   end

   // Result and valid registers; result holds while in_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z         <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            z    <= sum;
            cout <= carry[WIDTH];
         end
      end
   end

`ifdef Y_ADDER_OVF_EN
   logic ovf_c;

   assign ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (in_valid) begin
         ovf <= ovf_c;
      end
   end
`endif

endmodule : y_adder

// File: tb/tb_y_adder.sv
// Self-checking bench for y_adder: directed corner cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_y_adder;

   localparam int unsigned WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             in_valid;
   logic [WIDTH-1:0] z;
   logic             cout;
   logic             out_valid;
`ifdef Y_ADDER_OVF_EN
   logic             ovf;
`endif

   int unsigned n_checks;
   int unsigned n_fail;

   // Reference state: what the outputs should show after the most recent edge.
   logic [WIDTH-1:0] exp_z;
   logic             exp_cout;
   logic             exp_valid;
   logic             exp_ovf;

   y_adder #(.WIDTH(WIDTH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .in_valid  (in_valid),
      .z         (z),
      .cout      (cout),
      .out_valid (out_valid)
`ifdef Y_ADDER_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".z"}, 64'(z), 64'(exp_z));
      check({tag, ".cout"}, 64'(cout), 64'(exp_cout));
      check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
`ifdef Y_ADDER_OVF_EN
      check({tag, ".ovf"}, 64'(ovf), 64'(exp_ovf));
`endif
   endtask

   // Model the true mathematical result with wide integer arithmetic.
   task automatic model_edge(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                             input logic c, input logic v);
      longint unsigned usum;
      longint          ssum;
      longint          smax;
      longint          smin;
      exp_valid = v;
      if (v) begin
         usum     = longint'(x) + longint'(y) + longint'(c);
         exp_z    = WIDTH'(usum);
         exp_cout = usum >= (64'd1 << WIDTH);
         ssum     = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
         smax     = (64'sd1 <<< (WIDTH - 1)) - 64'sd1;
         smin     = -(64'sd1 <<< (WIDTH - 1));
         exp_ovf  = (ssum > smax) || (ssum < smin);
      end
   endtask

   task automatic model_reset();
      exp_z     = '0;
      exp_cout  = 1'b0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
   endtask

   // Drive one cycle, let the edge happen, then sample just after it.
   task automatic cycle(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic c, input logic v);
      a        = x;
      b        = y;
      cin      = c;
      in_valid = v;
      @(posedge clk);
      #1;
      model_edge(x, y, c, v);
      check_outputs(tag);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
      in_valid = 1'b0;
      model_reset();

      #3;
      check_outputs("reset_init");
      @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous reset while holding a nonzero result.
      cycle("load_1234", 32'h1234, 32'h0, 1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_reset");

      // In-flight operands during reset are discarded.
      a        = 32'd9;
      b        = 32'd9;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("reset_held");
      @(negedge clk);
      rst_n = 1'b1;
      cycle("after_reset", 32'd3, 32'd4, 1'b1, 1'b1);

      cycle("basic", 32'd5, 32'd7, 1'b0, 1'b1);
      check("basic_value", 64'(z), 64'd12);

      for (int i = 0; i < 3; i++) begin
         cycle("hold", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
         check("hold_value", 64'(z), 64'd12);
      end

      cycle("wrap_a", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
      check("wrap_a_sum", {31'd0, cout, z}, 64'h1_0000_0000);
      cycle("wrap_b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
      check("wrap_b_sum", {31'd0, cout, z}, 64'h1_FFFF_FFFF);

      cycle("ovf_pos", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1);
      check("ovf_pos_z", 64'(z), 64'h8000_0000);
      cycle("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
      check("ovf_neg_sum", {31'd0, cout, z}, 64'h1_0000_0000);
`ifdef Y_ADDER_OVF_EN
      check("ovf_neg_flag", 64'(ovf), 64'd1);
`endif

      // Back-to-back random traffic.
      for (int i = 0; i < 1000; i++) begin
         cycle("rand_b2b", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
      end

      // Random traffic with gaps in in_valid to exercise holding.
      for (int i = 0; i < 200; i++) begin
         cycle("rand_gap", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
               1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_y_adder

// File: doc/y_adder.md
Y_ADDER -- requirements
Module: y_adder

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result bit width (legal range 1..64).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: a  input  WIDTH  operand A, unsigned or two's complement.
REQ-005 Port: b  input  WIDTH  operand B.
REQ-006 Port: cin  input  1  carry-in; always driven 0 or 1.
REQ-007 Port: in_valid  input  1  a/b/cin qualify this cycle.
REQ-008 Port: z  output  WIDTH  registered sum, low WIDTH bits of a+b+cin.
REQ-009 Port: cout  output  1  registered carry-out, bit WIDTH of a+b+cin.
REQ-010 Port: out_valid  output  1  z/cout updated by the preceding edge.
REQ-011 Port: ovf  output  1  registered signed overflow; present only when Y_ADDER_OVF_EN is defined.

Function
REQ-012 The sum SHALL satisfy {cout,z} == a + b + cin exactly, computed at WIDTH+1 bits with no truncation of the carry.
REQ-013 Latency SHALL be exactly one clock: operands sampled on edge N with in_valid=1 appear on z/cout with out_valid=1 after edge N.
REQ-014 When in_valid=0 at an edge, z and cout SHALL hold their previous values and out_valid SHALL be 0.
REQ-015 Back-to-back in_valid=1 cycles SHALL be accepted every cycle; no stall or backpressure exists.
REQ-016 Wrap-around: all-ones + 0 + cin=1 SHALL give z=0, cout=1.
REQ-017 Combinational carry path SHALL be a ripple chain of 1-bit full adders; carry into bit 0 is cin, carry out of bit WIDTH-1 is cout.
REQ-018 Outputs SHALL depend only on registered state; there is no combinational input-to-output path.

Reset
REQ-019 Assertion of rst_n=0 SHALL immediately, without waiting for clk, force z=0, cout=0, out_valid=0, and ovf=0 when present.
REQ-020 Reset asserted mid-stream SHALL discard the in-flight result; the first edge after deassertion with in_valid=1 produces a fresh result one cycle later.
REQ-021 Deassertion SHALL be synchronized by the integrating system; the block requires no reset-release logic.

Configuration
REQ-022 With macro Y_ADDER_OVF_EN defined, port ovf SHALL exist and register (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]) under the same valid/hold rules as z.
REQ-023 Without Y_ADDER_OVF_EN, port ovf and its register SHALL be absent; all other behaviour is identical.

Structure
REQ-024 Package y_adder_pkg SHALL hold the default width constant (32) and the WIDTH legal-range constants.
REQ-025 Sub-module y_full_adder (ports a, b, cin, z, cout; z=a^b^cin, cout=majority) SHALL be instantiated WIDTH times in a generate loop.
REQ-026 y_adder SHALL contain only the ripple chain, the output/valid registers, and the optional overflow logic.

Verification
REQ-027 Reset: rst_n=0 asynchronously while z=0x1234 -> z=0, cout=0, out_valid=0 before the next clk edge.
REQ-028 Basic: a=5, b=7, cin=0, in_valid=1 -> after one edge z=12, cout=0, out_valid=1.
REQ-029 Wrap: a=0xFFFFFFFF, b=0, cin=1 -> z=0x00000000, cout=1; a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 -> z=0xFFFFFFFF, cout=1.
REQ-030 Hold: result z=12 then in_valid=0 for 3 cycles with changing a/b -> z stays 12, out_valid=0.
REQ-031 Random: 1000 back-to-back random a/b/cin -> every result matches a 33-bit reference {cout,z}=a+b+cin one cycle later.
REQ-032 Overflow, with Y_ADDER_OVF_EN: a=0x7FFFFFFF, b=1, cin=0 -> z=0x80000000, ovf=1, cout=0; a=0x80000000, b=0x80000000 -> z=0, ovf=1, cout=1.
